// File: rtl/program_loader.sv
`default_nettype none
// program_loader: frames a boot byte stream into 16-bit words, writes them to
// instruction memory at stride 2 and releases the core only on a good checksum.
module program_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd32768
) (
   input  logic        clk,
   input  logic        nRESET,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_rw,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_nreset,
   output logic        done,
   output logic        error
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LEN_LO = 4'd1;
   localparam logic [3:0] ST_LEN_HI = 4'd2;
   localparam logic [3:0] ST_DLO    = 4'd3;
   localparam logic [3:0] ST_DHI    = 4'd4;
   localparam logic [3:0] ST_WRITE  = 4'd5;
   localparam logic [3:0] ST_CHECK  = 4'd6;
   localparam logic [3:0] ST_DONE   = 4'd7;
   localparam logic [3:0] ST_ERROR  = 4'd8;

   logic [3:0]  state_q, state_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  csum_q, csum_d;
   logic        xfer;
   logic [15:0] len_w;

   // in_ready is decoded from state only, so there is no input-to-output path.
   assign xfer  = in_valid && in_ready;
   assign len_w = {in_data, lo_q};

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= ST_IDLE;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
         addr_q  <= BASE_ADDR;
         count_q <= 16'h0000;
         csum_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         csum_q  <= csum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      count_d = count_q;
      csum_d  = csum_q;
      if (xfer && (state_q != ST_CHECK)) begin
         csum_d = csum_q ^ in_data;
      end
      case (state_q)
         ST_IDLE: state_d = ST_LEN_LO;
         ST_LEN_LO: begin
            if (xfer) begin
               lo_d    = in_data;
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               count_d = len_w;
               if (len_w > MAX_WORDS) begin
                  state_d = ST_ERROR;
               end else if (len_w == 16'h0000) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DLO;
               end
            end
         end
         ST_DLO: begin
            if (xfer) begin
               lo_d    = in_data;
               state_d = ST_DHI;
            end
         end
         ST_DHI: begin
            if (xfer) begin
               hi_d    = in_data;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d  = addr_q + 16'd2;
            count_d = count_q - 16'd1;
            state_d = (count_q == 16'd1) ? ST_CHECK : ST_DLO;
         end
         ST_CHECK: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      mem_rw     = 1'b1;
      cpu_nreset = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state_q)
         ST_LEN_LO, ST_LEN_HI, ST_DLO, ST_DHI, ST_CHECK: in_ready = 1'b1;
         ST_WRITE: mem_rw = 1'b0;
         ST_DONE: begin
            cpu_nreset = 1'b1;
            done       = 1'b1;
         end
         ST_ERROR: error = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = {hi_q, lo_q};

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// tb_program_loader: randomized frames checked against a byte-level frame model.
module tb_program_loader;

   localparam logic [15:0] BASE = 16'h0000;
   localparam int          MAXW = 4;

   logic        clk = 1'b0;
   logic        nRESET = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        mem_rw;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_nreset;
   logic        done;
   logic        error;

   program_loader #(
      .BASE_ADDR(BASE),
      .MAX_WORDS(16'(MAXW))
   ) dut (
      .clk       (clk),
      .nRESET    (nRESET),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_nreset(cpu_nreset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  fr[$];
   logic [15:0] obs_a[$];
   logic [15:0] obs_d[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},   32'(in_ready),   32'd0);
      check({tag, "_mem_rw"},     32'(mem_rw),     32'd1);
      check({tag, "_mem_addr"},   32'(mem_addr),   32'(BASE));
      check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
      check({tag, "_cpu_nreset"}, 32'(cpu_nreset), 32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_error"},      32'(error),      32'd0);
   endtask

   task automatic reset_dut();
      in_valid = 1'b0;
      nRESET   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      nRESET = 1'b1;
   endtask

   task automatic build_frame(input int nw, input bit corrupt);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      fr.delete();
      b = 8'(nw);      fr.push_back(b); x ^= b;
      b = 8'(nw >> 8); fr.push_back(b); x ^= b;
      if (nw > MAXW) return;
      for (int i = 0; i < 2 * nw; i++) begin
         b = 8'($urandom_range(255));
         fr.push_back(b);
         x ^= b;
      end
      if (corrupt) x ^= 8'($urandom_range(255, 1));
      fr.push_back(x);
   endtask

   // Model: parse the frame bytes, compute expected writes and final outcome.
   task automatic run_frame(input string tag, input int gap_pct);
      int         n, idx, cyc, exp_n;
      bit         pending, took, exp_done, exp_err;
      logic [7:0] x;
      n = fr.size();
      exp_n = int'(fr[0]) | (int'(fr[1]) << 8);
      if (exp_n > MAXW) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         exp_n    = 0;
      end else begin
         x = 8'h00;
         for (int i = 0; i < n - 1; i++) x ^= fr[i];
         exp_done = (x == fr[n-1]);
         exp_err  = !exp_done;
      end
      obs_a.delete();
      obs_d.delete();
      idx = 0; cyc = 0; pending = 1'b0;
      while (idx < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!mem_rw) begin
            obs_a.push_back(mem_addr);
            obs_d.push_back(mem_wdata);
         end
         if (!pending) begin
            if (int'($urandom_range(99)) >= gap_pct) begin
               in_valid = 1'b1;
               in_data  = fr[idx];
            end else begin
               in_valid = 1'b0;
               in_data  = 8'($urandom_range(255));
            end
         end
         took = in_valid && in_ready;
         if (took) idx++;
         pending = in_valid && !took;
      end
      check({tag, "_bytes_consumed"}, 32'(idx), 32'(n));
      @(negedge clk);
      check({tag, "_done"},       32'(done),       32'(exp_done));
      check({tag, "_error"},      32'(error),      32'(exp_err));
      check({tag, "_cpu_nreset"}, 32'(cpu_nreset), 32'(exp_done));
      // Junk after the frame must be ignored by a terminal loader.
      for (int k = 0; k < 4; k++) begin
         if (!mem_rw) begin
            obs_a.push_back(mem_addr);
            obs_d.push_back(mem_wdata);
         end
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(255));
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_ready_after"}, 32'(in_ready), 32'd0);
      check({tag, "_done_hold"},   32'(done),     32'(exp_done));
      check({tag, "_error_hold"},  32'(error),    32'(exp_err));
      check({tag, "_nwrites"}, 32'(obs_a.size()), 32'(exp_n));
      for (int i = 0; i < exp_n && i < obs_a.size(); i++) begin
         check({tag, "_waddr"}, 32'(obs_a[i]), 32'(16'(BASE + 16'(2 * i))));
         check({tag, "_wdata"}, 32'(obs_d[i]), {16'h0, fr[3+2*i], fr[2+2*i]});
      end
   endtask

   task automatic load_nominal();
      fr.delete();
      fr.push_back(8'h02); fr.push_back(8'h00);
      fr.push_back(8'h34); fr.push_back(8'h12);
      fr.push_back(8'hCD); fr.push_back(8'hAB);
      fr.push_back(8'h42);
   endtask

   initial begin
      int cyc;
      in_valid = 1'b0;
      nRESET   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("init");
      nRESET = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(in_ready), 32'd1);

      load_nominal();
      run_frame("nominal", 0);

      // Asynchronous reset out of DONE, away from any clock edge.
      #2 nRESET = 1'b0;
      #1;
      check("async_cpu_nreset", 32'(cpu_nreset), 32'd0);
      check("async_done",       32'(done),       32'd0);

      reset_dut();
      load_nominal();
      fr[6] = 8'h43;
      run_frame("badsum", 0);

      reset_dut();
      fr.delete();
      fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00);
      run_frame("empty", 0);

      reset_dut();
      load_nominal();
      run_frame("gaps", 50);

      reset_dut();
      fr.delete();
      fr.push_back(8'h05); fr.push_back(8'h00);
      run_frame("oversize", 0);

      reset_dut();
      build_frame(MAXW, 1'b0);
      run_frame("maxwords", 30);

      // Reset during the first WRITE cycle cancels it immediately.
      reset_dut();
      load_nominal();
      cyc = 0;
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = fr[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      while (mem_rw && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("midload_write_seen", 32'(mem_rw),    32'd0);
      check("midload_wdata",      32'(mem_wdata), 32'h1234);
      #1 nRESET = 1'b0;
      #1;
      check_reset_values("midload");
      reset_dut();
      run_frame("reload", 20);

      for (int t = 0; t < 20; t++) begin
         reset_dut();
         build_frame(int'($urandom_range(MAXW + 1)), ($urandom_range(3) == 0));
         run_frame("random", int'($urandom_range(60)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
